// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg : shared opcodes, default float geometry, scheduler state encoding
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

  localparam int FPU_NEXP = 8;
  localparam int FPU_NSIG = 23;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_CMP = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } sched_state_e;

  // Encodings above OP_CMP have no ALU meaning.
  function automatic logic op_is_valid(input logic [2:0] op);
    return (op <= OP_CMP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_rr_arbiter : 2-way round-robin arbiter with one-hot grant
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       update_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // After a grant the pointer favours the requester that just lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (update_i && (|grant_o)) begin
      ptr_q <= grant_o[0];
    end
  end

endmodule

`default_nettype wire

// File: rtl/fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// fpu_op_scheduler : arbitrates two requesters onto a shared FP ALU
// Optional macro FPU_SCHED_STATS_EN adds ops_cnt / exc_cnt outputs.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fpu_op_scheduler
  import fpu_pkg::*;
#(
  parameter int NEXP    = FPU_NEXP,
  parameter int NSIG    = FPU_NSIG,
  parameter int ALU_LAT = 1,
  parameter int DIV_LAT = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [NEXP+NSIG:0]   req0_a,
  input  logic [NEXP+NSIG:0]   req0_b,
  input  logic [2:0]           req0_opcode,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [NEXP+NSIG:0]   req1_a,
  input  logic [NEXP+NSIG:0]   req1_b,
  input  logic [2:0]           req1_opcode,
  output logic [NEXP+NSIG:0]   alu_a,
  output logic [NEXP+NSIG:0]   alu_b,
  output logic [2:0]           alu_opcode,
  input  logic [NEXP+NSIG:0]   alu_p,
  input  logic                 alu_ovf,
  input  logic                 alu_unf,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [NEXP+NSIG:0]   rsp_p,
  output logic                 rsp_ovf,
  output logic                 rsp_unf,
  output logic                 rsp_id,
  output logic                 busy
`ifdef FPU_SCHED_STATS_EN
  ,
  output logic [31:0]          ops_cnt,
  output logic [31:0]          exc_cnt
`endif
);

  localparam int W      = NEXP + NSIG + 1;
  localparam int MAXLAT = (DIV_LAT > ALU_LAT) ? DIV_LAT : ALU_LAT;
  localparam int CNT_W  = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

  sched_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_load_d;
  logic [W-1:0]     alu_a_q, alu_b_q;
  logic [2:0]       alu_opcode_q;
  logic             id_q;
  logic             rsp_valid_q, rsp_ovf_q, rsp_unf_q, rsp_id_q;
  logic [W-1:0]     rsp_p_q;

  logic [1:0]       req_valid_w;
  logic [1:0]       grant_w;
  logic             arb_en_w;
  logic [W-1:0]     sel_a_w, sel_b_w;
  logic [2:0]       sel_op_w;

  assign req_valid_w = {req1_valid, req0_valid};
  // Held off during reset so no requester sees a handshake that is then dropped.
  assign arb_en_w    = (state_q == ST_IDLE) && (|req_valid_w) && !rst;

  fpu_rr_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (req_valid_w),
    .update_i (arb_en_w),
    .grant_o  (grant_w)
  );

  assign req0_ready = arb_en_w & grant_w[0];
  assign req1_ready = arb_en_w & grant_w[1];

  assign sel_a_w  = grant_w[1] ? req1_a      : req0_a;
  assign sel_b_w  = grant_w[1] ? req1_b      : req0_b;
  assign sel_op_w = grant_w[1] ? req1_opcode : req0_opcode;

  always_comb begin
    cnt_load_d = '0;
    if (sel_op_w == OP_DIV) begin
      cnt_load_d = CNT_W'(DIV_LAT - 1);
    end else if (op_is_valid(sel_op_w)) begin
      cnt_load_d = CNT_W'(ALU_LAT - 1);
    end
  end

`ifdef FPU_SCHED_STATS_EN
  logic [31:0] ops_cnt_q, exc_cnt_q;
  assign ops_cnt = ops_cnt_q;
  assign exc_cnt = exc_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ops_cnt_q <= '0;
      exc_cnt_q <= '0;
    end else if ((state_q == ST_DONE) && rsp_ready) begin
      ops_cnt_q <= ops_cnt_q + 32'd1;
      if (rsp_ovf_q || rsp_unf_q) begin
        exc_cnt_q <= exc_cnt_q + 32'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_opcode_q <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_p_q      <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_unf_q    <= 1'b0;
      rsp_id_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid_w) begin
            alu_a_q      <= sel_a_w;
            alu_b_q      <= sel_b_w;
            alu_opcode_q <= sel_op_w;
            id_q         <= grant_w[1];
            cnt_q        <= cnt_load_d;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cnt_q == '0) begin
            state_q     <= ST_DONE;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            if (!op_is_valid(alu_opcode_q)) begin
              rsp_p_q   <= '0;
              rsp_ovf_q <= 1'b0;
              rsp_unf_q <= 1'b0;
            end else if (alu_opcode_q == OP_CMP) begin
              rsp_p_q   <= alu_p;
              rsp_ovf_q <= 1'b0;
              rsp_unf_q <= 1'b0;
            end else begin
              rsp_p_q   <= alu_p;
              rsp_ovf_q <= alu_ovf;
              rsp_unf_q <= alu_unf;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_p      = rsp_p_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_unf    = rsp_unf_q;
  assign rsp_id     = rsp_id_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fpu_op_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fpu_op_scheduler : directed + randomized bench with latency-aware ALU model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fpu_op_scheduler;

  localparam int NEXP    = 8;
  localparam int NSIG    = 23;
  localparam int W       = NEXP + NSIG + 1;
  localparam int ALU_LAT = 1;
  localparam int DIV_LAT = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]   req0_opcode, req1_opcode;
  logic [W-1:0] alu_a, alu_b, alu_p;
  logic [2:0]   alu_opcode;
  logic         alu_ovf, alu_unf;
  logic         rsp_valid, rsp_ready, rsp_ovf, rsp_unf, rsp_id, busy;
  logic [W-1:0] rsp_p;
`ifdef FPU_SCHED_STATS_EN
  logic [31:0]  ops_cnt, exc_cnt;
`endif

  fpu_op_scheduler #(
    .NEXP(NEXP), .NSIG(NSIG), .ALU_LAT(ALU_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_b(req0_b), .req0_opcode(req0_opcode),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_b(req1_b), .req1_opcode(req1_opcode),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_p(alu_p), .alu_ovf(alu_ovf), .alu_unf(alu_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .rsp_ovf(rsp_ovf), .rsp_unf(rsp_unf), .rsp_id(rsp_id), .busy(busy)
`ifdef FPU_SCHED_STATS_EN
    , .ops_cnt(ops_cnt), .exc_cnt(exc_cnt)
`endif
  );

  // Stand-in ALU: known IEEE cases from a table, otherwise a deterministic hash.
  function automatic logic [W+1:0] alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    logic [W-1:0] p;
    logic         ovf, unf;
    if (op == 3'b000 && a == 32'h3F800000 && b == 32'h40000000) return {2'b00, 32'h40400000};
    if (op == 3'b011 && a == 32'h41200000 && b == 32'h40000000) return {2'b00, 32'h40A00000};
    if (op == 3'b010 && a == 32'h7F000000 && b == 32'h7F000000) return {2'b10, 32'h7F800000};
    p   = (a ^ {b[15:0], b[31:16]}) + ({29'd0, op} * 32'h9E3779B9);
    ovf = p[3] & p[7];
    unf = p[5] & ~ovf;
    return {ovf, unf, p};
  endfunction

  function automatic int lat_of(input logic [2:0] op);
    if (op == 3'b011) return DIV_LAT;
    if (op <= 3'b100) return ALU_LAT;
    return 1;
  endfunction

  function automatic logic [W+1:0] expect_rsp(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] op);
    logic [W+1:0] r;
    r = alu_ref(a, b, op);
    if (op > 3'b100) return '0;
    if (op == 3'b100) return {2'b00, r[W-1:0]};
    return r;
  endfunction

  // The ALU only yields a correct result once its operands have been stable
  // for the opcode's full latency; earlier it returns the complement.
  logic [2*W+2:0] cur_ops;
  logic [2*W+2:0] last_ops = '1;
  int             age_q = 0;
  int             eff_age;
  logic [W+1:0]   alu_raw;
  logic           alu_ok;

  assign cur_ops = {alu_opcode, alu_a, alu_b};
  always_comb eff_age = (cur_ops == last_ops) ? age_q + 1 : 1;
  always @(posedge clk) begin
    last_ops <= cur_ops;
    age_q    <= (eff_age > 1000) ? 1000 : eff_age;
  end
  assign alu_raw = alu_ref(alu_a, alu_b, alu_opcode);
  assign alu_ok  = (eff_age >= lat_of(alu_opcode));
  assign alu_p   = alu_ok ? alu_raw[W-1:0] : ~alu_raw[W-1:0];
  assign alu_ovf = alu_ok ? alu_raw[W+1]   : ~alu_raw[W+1];
  assign alu_unf = alu_ok ? alu_raw[W]     : ~alu_raw[W];

  int          checks = 0;
  int          errors = 0;
  int          rr_ptr = 0;
  logic [31:0] m_ops  = 0;
  logic [31:0] m_exc  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_stats();
`ifdef FPU_SCHED_STATS_EN
    chk("ops_cnt", ops_cnt, m_ops);
    chk("exc_cnt", exc_cnt, m_exc);
`endif
  endtask

  task automatic start(input logic [1:0] vm,
                       input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                       input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                       output int win);
    req0_valid = vm[0]; req0_a = a0; req0_b = b0; req0_opcode = op0;
    req1_valid = vm[1]; req1_a = a1; req1_b = b1; req1_opcode = op1;
    #1;
    win = (vm == 2'b01) ? 0 : (vm == 2'b10) ? 1 : rr_ptr;
    chk("grant", {req1_ready, req0_ready}, 64'd1 << win);
    chk("idle_busy", busy, 1'b0);
    step();
    rr_ptr = 1 - win;
    if (win == 0) req0_valid = 1'b0;
    else          req1_valid = 1'b0;
  endtask

  task automatic exec_phase(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] op);
    for (int k = 1; k <= n; k++) begin
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      chk("exec_busy", busy, 1'b1);
      chk("exec_rspv", rsp_valid, 1'b0);
      chk("exec_rdy", {req1_ready, req0_ready}, 2'b00);
      chk("exec_alu_opa", {alu_opcode, alu_a}, {op, a});
      chk("exec_alu_b", alu_b, b);
      step();
    end
  endtask

  task automatic resp_phase(input logic [W+1:0] exp, input int id, input int hold);
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      #1;
      chk("done_rspv", rsp_valid, 1'b1);
      chk("done_busy", busy, 1'b1);
      chk("rsp_p", rsp_p, exp[W-1:0]);
      chk("rsp_flags", {rsp_ovf, rsp_unf}, exp[W+1:W]);
      chk("rsp_id", rsp_id, id[0]);
      chk("done_rdy", {req1_ready, req0_ready}, 2'b00);
      step();
    end
    rsp_ready = 1'b0;
    m_ops = m_ops + 1;
    if (exp[W+1] | exp[W]) m_exc = m_exc + 1;
    chk("post_rspv", rsp_valid, 1'b0);
    chk("post_busy", busy, 1'b0);
    chk_stats();
  endtask

  task automatic txn(input logic [1:0] vm,
                     input logic [W-1:0] a0, input logic [W-1:0] b0, input logic [2:0] op0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic [2:0] op1,
                     input int hold, input int exp_win);
    int           win;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    start(vm, a0, b0, op0, a1, b1, op1, win);
    if (exp_win >= 0) chk("winner", win, exp_win);
    a  = win ? a1 : a0;
    b  = win ? b1 : b0;
    op = win ? op1 : op0;
    exec_phase(lat_of(op), a, b, op);
    resp_phase(expect_rsp(a, b, op), win, hold);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {busy, rsp_valid, rsp_ovf, rsp_unf, rsp_id, req1_ready, req0_ready}, 7'd0);
    chk({tag, "_alu"}, {alu_opcode, alu_a}, 35'd0);
    chk({tag, "_alub"}, alu_b, 32'd0);
    chk({tag, "_rspp"}, rsp_p, 32'd0);
    chk_stats();
  endtask

  initial begin
    int           dummy;
    logic [1:0]   vm;
    logic [2:0]   o0, o1;
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_opcode = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_opcode = '0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk_all_zero("reset");

    // add 1.0 + 2.0 from requester 0 alone
    txn(2'b01, 32'h3F800000, 32'h40000000, 3'b000, '0, '0, '0, 0, 0);

    // both requesters contending: grants must alternate
    for (int i = 0; i < 4; i++) begin
      txn(2'b11, 32'h1000 + i, 32'h2000 + i, 3'b010, 32'h3000 + i, 32'h4000 + i, 3'b001, 0,
          (i % 2 == 0) ? 1 : 0);
    end

    // divide 10.0 / 2.0 from requester 1
    txn(2'b10, '0, '0, '0, 32'h41200000, 32'h40000000, 3'b011, 0, 1);

    // response back-pressured for 10 cycles with both requesters waiting
    txn(2'b11, 32'h12345678, 32'h9ABCDEF0, 3'b000, 32'h0F0F0F0F, 32'h33333333, 3'b100, 10, -1);

    // invalid opcode, then overflowing multiply
    txn(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b111, '0, '0, '0, 0, 0);
    txn(2'b10, '0, '0, '0, 32'h7F000000, 32'h7F000000, 3'b010, 1, 1);

    // reset on the fifth EXEC cycle of a divide
    start(2'b01, 32'h41200000, 32'h40000000, 3'b011, '0, '0, '0, dummy);
    exec_phase(4, 32'h41200000, 32'h40000000, 3'b011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rr_ptr = 0; m_ops = 0; m_exc = 0;
    #1;
    chk_all_zero("midrst");
    for (int i = 0; i < 30; i++) begin
      step();
      chk("midrst_norsp", {rsp_valid, busy}, 2'b00);
    end
    txn(2'b11, 32'h40400000, 32'h3F800000, 3'b001, 32'h40800000, 32'h40000000, 3'b000, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      vm = 2'($urandom_range(1, 3));
      o0 = 3'($urandom_range(0, 7));
      o1 = 3'($urandom_range(0, 7));
      txn(vm, $urandom, $urandom, o0, $urandom, $urandom, o1, $urandom_range(0, 3), -1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("final_idle", {busy, rsp_valid}, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
